// File: rtl/pipelined_fixed_multiplier_if.sv
// Operand/result stream bundle for pipelined_fixed_multiplier.
// Handshake: a beat moves on a rising edge where valid && ready; the producer keeps the payload
// stable while valid is high and ready is low; ready may depend combinationally on downstream ready.
interface pipelined_fixed_multiplier_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] w;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dout;
    logic              ovf;

    modport master (
        output in_valid, din, w, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din, w, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/pipelined_fixed_multiplier.sv
// Signed fixed-point multiplier: exact full product, floor or round-half-up scaling,
// optional saturation, PIPE register stages with a global stall on output backpressure.
module pipelined_fixed_multiplier #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 14,
    parameter int PIPE       = 3,
    parameter int ROUND_MODE = 0,
    parameter int SAT_EN     = 1
) (
    input logic                         clk,
    input logic                         rst,
    pipelined_fixed_multiplier_if.slave bus
);
    localparam int                PW         = 2 * DATA_W;
    localparam logic [PW:0]       ROUND_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]       ROUND_HALF = (ROUND_MODE != 0) ? (ROUND_ONE << (FRAC_W - 1)) : '0;
    localparam logic [DATA_W-1:0] SAT_POS    = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_NEG    = {1'b1, {(DATA_W - 1){1'b0}}};

    logic                 w_adv;
    logic [PIPE:1]        r_vld;
    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod_in;
    logic signed [PW-1:0] w_prod_last;
    logic signed [PW:0]   w_rnd_sum;
    logic signed [PW:0]   w_r;
    logic [PW:DATA_W-1]   w_r_hi;
    logic                 w_ovf;
    logic [DATA_W-1:0]    w_dout;
    logic [DATA_W-1:0]    r_dout;
    logic                 r_ovf;

    // Whole pipeline moves together; a held output freezes every stage behind it.
    assign w_adv         = !r_vld[PIPE] || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[PIPE];
    assign bus.dout      = r_dout;
    assign bus.ovf       = r_ovf;

    assign w_a_ext   = {{DATA_W{bus.din[DATA_W-1]}}, bus.din};
    assign w_b_ext   = {{DATA_W{bus.w[DATA_W-1]}}, bus.w};
    assign w_prod_in = w_a_ext * w_b_ext;

    generate
        if (PIPE == 1) begin : g_no_prod_stage
            assign w_prod_last = w_prod_in;
        end else begin : g_prod_stages
            logic signed [PW-1:0] r_prod [1:PIPE-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 1; s < PIPE; s++) r_prod[s] <= '0;
                end else if (w_adv) begin
                    r_prod[1] <= w_prod_in;
                    for (int s = 2; s < PIPE; s++) r_prod[s] <= r_prod[s-1];
                end
            end

            assign w_prod_last = r_prod[PIPE-1];
        end
    endgenerate

    // One extra bit keeps the rounding add from wrapping on the largest positive product.
    assign w_rnd_sum = $signed({w_prod_last[PW-1], w_prod_last}) + $signed(ROUND_HALF);
    assign w_r       = w_rnd_sum >>> FRAC_W;
    assign w_r_hi    = w_r[PW:DATA_W-1];
    assign w_ovf     = !((&w_r_hi) || !(|w_r_hi));

    always_comb begin
        w_dout = w_r[DATA_W-1:0];
        if (w_ovf && (SAT_EN != 0)) begin
            w_dout = w_r[PW] ? SAT_NEG : SAT_POS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_vld[1] <= bus.in_valid;
            for (int s = 2; s <= PIPE; s++) r_vld[s] <= r_vld[s-1];
            r_dout <= w_dout;
            r_ovf  <= w_ovf;
        end
    end
endmodule

// File: tb/tb_pipelined_fixed_multiplier.sv
// Bench for pipelined_fixed_multiplier: main DUT (PIPE=3, floor, saturate) plus three other
// configurations sharing the same stimulus, each checked by a queue-based scoreboard.
module tb_pipelined_fixed_multiplier;
    localparam int DW        = 16;
    localparam int FW        = 14;
    localparam int MAIN_PIPE = 3;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic done;
    logic [DW:0] exp_q[$];

    pipelined_fixed_multiplier_if #(.DATA_W(DW)) if_main();

    pipelined_fixed_multiplier #(
        .DATA_W(DW), .FRAC_W(FW), .PIPE(MAIN_PIPE), .ROUND_MODE(0), .SAT_EN(1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(if_main)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [DW:0] ref_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input int rm, input int sat);
        longint p;
        longint r;
        logic   o;
        logic [DW-1:0] d;
        p = longint'($signed(a)) * longint'($signed(b));
        if (rm != 0) p = p + (longint'(1) <<< (FW - 1));
        r = p >>> FW;
        o = (r > 32767) || (r < -32768);
        if (o && sat != 0) d = (r > 0) ? 16'h7FFF : 16'h8000;
        else d = 16'(r);
        return {o, d};
    endfunction

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 9))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- extra configurations ----------------
    for (genvar g = 0; g < 3; g++) begin : g_x
        localparam int P   = (g == 0) ? 1 : 6;
        localparam int RM  = (g == 2) ? 0 : 1;
        localparam int SAT = (g == 1) ? 1 : 0;
        logic [DW:0] exp_q[$];

        pipelined_fixed_multiplier_if #(.DATA_W(DW)) if_x();
        assign if_x.in_valid  = if_main.in_valid;
        assign if_x.din       = if_main.din;
        assign if_x.w         = if_main.w;
        assign if_x.out_ready = if_main.out_ready;

        pipelined_fixed_multiplier #(
            .DATA_W(DW), .FRAC_W(FW), .PIPE(P), .ROUND_MODE(RM), .SAT_EN(SAT)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(if_x)
        );

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                check($sformatf("x%0d_in_ready", g), 32'(if_x.in_ready),
                      32'(!if_x.out_valid || if_x.out_ready));
                if (if_x.out_valid) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("x%0d_spurious_valid", g), 32'(if_x.out_valid), 32'(0));
                    end else begin
                        check($sformatf("x%0d_dout", g), 32'(if_x.dout), 32'(exp_q[0][DW-1:0]));
                        check($sformatf("x%0d_ovf", g), 32'(if_x.ovf), 32'(exp_q[0][DW]));
                        if (if_x.out_ready) void'(exp_q.pop_front());
                    end
                end
                if (if_x.in_valid && if_x.in_ready)
                    exp_q.push_back(ref_model(if_x.din, if_x.w, RM, SAT));
            end
        end
    end

    // ---------------- main scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("main_in_ready", 32'(if_main.in_ready),
                  32'(!if_main.out_valid || if_main.out_ready));
            if (if_main.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("main_spurious_valid", 32'(if_main.out_valid), 32'(0));
                end else begin
                    check("main_dout", 32'(if_main.dout), 32'(exp_q[0][DW-1:0]));
                    check("main_ovf", 32'(if_main.ovf), 32'(exp_q[0][DW]));
                    if (if_main.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW:0] exp);
        int waited;
        waited = 0;
        if_main.in_valid = 1'b1;
        if_main.din      = a;
        if_main.w        = b;
        forever begin
            @(negedge clk);
            if (if_main.in_ready && !rst) begin
                exp_q.push_back(exp);
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 32'(if_main.in_ready), 32'(1));
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        if_main.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        if_main.in_valid  = 1'b0;
        if_main.out_ready = 1'b1;
        while ((exp_q.size() + g_x[0].exp_q.size() + g_x[1].exp_q.size() + g_x[2].exp_q.size()) != 0
               && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("main_leftover", 32'(exp_q.size()), 32'(0));
        check("x0_leftover", 32'(g_x[0].exp_q.size()), 32'(0));
        check("x1_leftover", 32'(g_x[1].exp_q.size()), 32'(0));
        check("x2_leftover", 32'(g_x[2].exp_q.size()), 32'(0));
    endtask

    // Cycles counted from the cycle the sample is presented and accepted to the first out_valid cycle.
    task automatic latency_test(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW:0] exp);
        int lat;
        if_main.out_ready = 1'b1;
        if_main.in_valid  = 1'b1;
        if_main.din       = a;
        if_main.w         = b;
        @(negedge clk);
        check("lat_in_ready", 32'(if_main.in_ready), 32'(1));
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if_main.in_valid = 1'b0;
        lat = 1;
        while (!if_main.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(MAIN_PIPE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        done              = 1'b0;
        rst               = 1'b1;
        if_main.in_valid  = 1'b0;
        if_main.din       = '0;
        if_main.w         = '0;
        if_main.out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(if_main.out_valid), 32'(0));
        check("rst_dout", 32'(if_main.dout), 32'(0));
        check("rst_ovf", 32'(if_main.ovf), 32'(0));
        check("rst_in_ready", 32'(if_main.in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed values with hand-computed results for the main configuration.
        latency_test(16'h4000, 16'h2000, {1'b0, 16'h2000});
        send(16'h8000, 16'h8000, {1'b1, 16'h7FFF});
        send(16'h0001, 16'h2000, {1'b0, 16'h0000});
        send(16'hC000, 16'h0001, {1'b0, 16'hFFFF});
        send(16'h7FFF, 16'h7FFF, {1'b1, 16'h7FFF});
        send(16'h8000, 16'h4000, {1'b0, 16'h8000});
        send(16'h8000, 16'h4001, {1'b1, 16'h8000});
        send(16'h0001, 16'h0001, {1'b0, 16'h0000});
        idle(1);
        drain();

        // Eight back-to-back samples with a 4-cycle output stall in the middle.
        fork
            begin : stream
                for (int i = 0; i < 8; i++) begin
                    a = rand_op();
                    b = rand_op();
                    send(a, b, ref_model(a, b, 0, 1));
                end
                if_main.in_valid = 1'b0;
            end
            begin : stall
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                if_main.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_out_valid", 32'(if_main.out_valid), 32'(1));
                    check("stall_in_ready", 32'(if_main.in_ready), 32'(0));
                    @(posedge clk);
                    #1;
                end
                if_main.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with samples in flight.
        for (int i = 0; i < 3; i++) begin
            a = rand_op();
            b = rand_op();
            send(a, b, ref_model(a, b, 0, 1));
        end
        if_main.in_valid  = 1'b0;
        if_main.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 32'(if_main.out_valid), 32'(1));
        rst              = 1'b1;
        if_main.in_valid = 1'b1;
        if_main.din      = 16'h4000;
        if_main.w        = 16'h4000;
        #1;
        check("async_rst_out_valid", 32'(if_main.out_valid), 32'(0));
        check("async_rst_dout", 32'(if_main.dout), 32'(0));
        check("async_rst_ovf", 32'(if_main.ovf), 32'(0));
        check("async_rst_in_ready", 32'(if_main.in_ready), 32'(1));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst               = 1'b0;
        if_main.in_valid  = 1'b0;
        if_main.out_ready = 1'b1;
        idle(8);
        latency_test(16'hE000, 16'h3000, ref_model(16'hE000, 16'h3000, 0, 1));
        drain();

        // Random operands with random in_valid gaps and out_ready backpressure.
        fork
            begin : rand_stim
                for (int i = 0; i < 300; i++) begin
                    a = rand_op();
                    b = rand_op();
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send(a, b, ref_model(a, b, 0, 1));
                end
                if_main.in_valid = 1'b0;
                done = 1'b1;
            end
            begin : rand_ready
                while (!done) begin
                    if_main.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                if_main.out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
